// File: rtl/acc_pkg.sv
// Shared constants, lane state encoding and the requantisation function
// for the accumulator array.
package acc_pkg;

  localparam int unsigned DEF_N_COL  = 16;
  localparam int unsigned DEF_PSUM_W = 8;
  localparam int unsigned DEF_ACC_W  = 20;
  localparam int unsigned DEF_OUT_W  = 8;
  localparam int unsigned DEF_CH_W   = 6;
  localparam int unsigned DEF_OF_W   = 5;
  localparam int unsigned DEF_SH_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } lane_state_e;

  // Round-half-up arithmetic shift, optional ReLU, then saturate to out_w bits.
  function automatic longint requant(input longint acc, input int unsigned shift,
                                     input logic relu_en, input int unsigned out_w);
    longint r;
    longint hi;
    longint lo;
    r = acc;
    if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
    r  = r >>> shift;
    if (relu_en && (r < 0)) r = 0;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/accumulator_lane.sv
// One accumulator lane: sums ifmap_ch psums per pixel, requantises the sum and
// holds it in an output register with valid/ready backpressure.
module accumulator_lane
  import acc_pkg::*;
#(
  parameter int unsigned PSUM_W = DEF_PSUM_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned CH_W   = DEF_CH_W,
  parameter int unsigned ADDR_W = 2 * DEF_OF_W,
  parameter int unsigned SH_W   = DEF_SH_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CH_W-1:0]   ifmap_ch_i,
  input  logic [ADDR_W-1:0] last_pix_i,
  input  logic [SH_W-1:0]   shift_i,
  input  logic              relu_en_i,
  input  logic [PSUM_W-1:0] psum_i,
  input  logic              pvalid_i,
  output logic              pready_o,
  output logic              conv_valid_o,
  input  logic              conv_ready_i,
  output logic              conv_last_o,
  output logic [OUT_W-1:0]  conv_result_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              idle_o
);

  lane_state_e              state_q;
  logic [CH_W-1:0]          ch_cnt_q;
  logic [ADDR_W-1:0]        pix_cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     valid_q;
  logic                     last_q;
  logic [OUT_W-1:0]         result_q;
  logic [ADDR_W-1:0]        addr_q;

  logic signed [ACC_W-1:0]  psum_ext;
  logic signed [ACC_W-1:0]  acc_d;
  logic [OUT_W-1:0]         result_d;
  logic                     accept;
  logic                     out_fire;
  logic                     final_psum;
  logic                     last_pix;

  // Input may only be taken when the output register is free or draining now.
  assign pready_o   = (state_q == RUN) && !(valid_q && !conv_ready_i);
  assign accept     = pvalid_i && pready_o;
  assign out_fire   = valid_q && conv_ready_i;
  assign final_psum = (ch_cnt_q == CH_W'(ifmap_ch_i - CH_W'(1)));
  assign last_pix   = (pix_cnt_q == last_pix_i);

  assign psum_ext = ACC_W'($signed(psum_i));
  assign acc_d    = (ch_cnt_q == '0) ? psum_ext : acc_q + psum_ext;
  assign result_d = OUT_W'(requant(longint'(acc_d), 32'(shift_i), relu_en_i, OUT_W));

  assign conv_valid_o  = valid_q;
  assign conv_last_o   = last_q;
  assign conv_result_o = result_q;
  assign addr_o        = addr_q;
  assign idle_o        = (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      result_q  <= '0;
      addr_q    <= '0;
    end else begin
      if (out_fire) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= RUN;
            ch_cnt_q  <= '0;
            pix_cnt_q <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            acc_q <= acc_d;
            if (final_psum) begin
              ch_cnt_q  <= '0;
              pix_cnt_q <= pix_cnt_q + ADDR_W'(1);
              valid_q   <= 1'b1;
              result_q  <= result_d;
              addr_q    <= pix_cnt_q;
              last_q    <= last_pix;
              if (last_pix) state_q <= DRAIN;
            end else begin
              ch_cnt_q <= ch_cnt_q + CH_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_fire) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/accumulator_array.sv
// N_COL-lane accumulator between the systolic array and the activation stage:
// shared run configuration, per-lane accumulators and run-level busy/done.
module accumulator_array
  import acc_pkg::*;
#(
  parameter int unsigned N_COL  = DEF_N_COL,
  parameter int unsigned PSUM_W = DEF_PSUM_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned CH_W   = DEF_CH_W,
  parameter int unsigned OF_W   = DEF_OF_W,
  parameter int unsigned SH_W   = DEF_SH_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [OF_W-1:0]           ofmap_size_i,
  input  logic [CH_W-1:0]           ifmap_ch_i,
  input  logic [SH_W-1:0]           shift_i,
  input  logic                      relu_en_i,
  output logic                      busy_o,
  output logic                      done_o,
  input  logic [N_COL*PSUM_W-1:0]   psum_i,
  input  logic [N_COL-1:0]          pvalid_i,
  output logic [N_COL-1:0]          pready_o,
  output logic [N_COL-1:0]          conv_valid_o,
  input  logic [N_COL-1:0]          conv_ready_i,
  output logic [N_COL-1:0]          conv_last_o,
  output logic [N_COL*OUT_W-1:0]    conv_result_o,
  output logic [N_COL*2*OF_W-1:0]   addr_o
);

  localparam int unsigned ADDR_W = 2 * OF_W;

  if (ACC_W < PSUM_W + CH_W) begin : g_acc_w_check
    $error("accumulator_array: ACC_W must be at least PSUM_W + CH_W");
  end

  logic [CH_W-1:0]   ch_q;
  logic [ADDR_W-1:0] last_pix_q;
  logic [SH_W-1:0]   shift_q;
  logic              relu_q;
  logic              run_q;
  logic              done_q;

  logic [N_COL-1:0]  lane_idle;
  logic              all_idle;
  logic              start_ok;
  logic [ADDR_W-1:0] of_ext;
  logic [ADDR_W-1:0] last_pix_d;

  assign all_idle   = &lane_idle;
  assign start_ok   = start_i && all_idle && (|ifmap_ch_i) && (|ofmap_size_i);
  assign of_ext     = ADDR_W'(ofmap_size_i);
  assign last_pix_d = (of_ext * of_ext) - ADDR_W'(1);

  assign busy_o = !all_idle;
  assign done_o = done_q;

  // Config latch plus run tracking so done fires once per accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q       <= '0;
      last_pix_q <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= run_q && all_idle;
      if (start_ok) begin
        ch_q       <= ifmap_ch_i;
        last_pix_q <= last_pix_d;
        shift_q    <= shift_i;
        relu_q     <= relu_en_i;
        run_q      <= 1'b1;
      end else if (all_idle) begin
        run_q <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < N_COL; c++) begin : g_lane
    accumulator_lane #(
      .PSUM_W (PSUM_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
      .CH_W   (CH_W),
      .ADDR_W (ADDR_W),
      .SH_W   (SH_W)
    ) u_lane (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_ok),
      .ifmap_ch_i    (ch_q),
      .last_pix_i    (last_pix_q),
      .shift_i       (shift_q),
      .relu_en_i     (relu_q),
      .psum_i        (psum_i[c*PSUM_W +: PSUM_W]),
      .pvalid_i      (pvalid_i[c]),
      .pready_o      (pready_o[c]),
      .conv_valid_o  (conv_valid_o[c]),
      .conv_ready_i  (conv_ready_i[c]),
      .conv_last_o   (conv_last_o[c]),
      .conv_result_o (conv_result_o[c*OUT_W +: OUT_W]),
      .addr_o        (addr_o[c*ADDR_W +: ADDR_W]),
      .idle_o        (lane_idle[c])
    );
  end

endmodule

// File: tb/tb_accumulator_array.sv
// Bench for accumulator_array: constant vectors, hand sequences and randomized
// streams checked against a per-lane arithmetic reference model.
module tb_accumulator_array;

  localparam int N_COL  = 16;
  localparam int PSUM_W = 8;
  localparam int ACC_W  = 20;
  localparam int OUT_W  = 8;
  localparam int CH_W   = 6;
  localparam int OF_W   = 5;
  localparam int SH_W   = 5;
  localparam int ADDR_W = 2 * OF_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start_i;
  logic [OF_W-1:0]         ofmap_size_i;
  logic [CH_W-1:0]         ifmap_ch_i;
  logic [SH_W-1:0]         shift_i;
  logic                    relu_en_i;
  logic                    busy_o;
  logic                    done_o;
  logic [N_COL*PSUM_W-1:0] psum_i;
  logic [N_COL-1:0]        pvalid_i;
  logic [N_COL-1:0]        pready_o;
  logic [N_COL-1:0]        conv_valid_o;
  logic [N_COL-1:0]        conv_ready_i;
  logic [N_COL-1:0]        conv_last_o;
  logic [N_COL*OUT_W-1:0]  conv_result_o;
  logic [N_COL*ADDR_W-1:0] addr_o;

  always #5 clk = ~clk;

  accumulator_array #(
    .N_COL(N_COL), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .CH_W(CH_W), .OF_W(OF_W), .SH_W(SH_W)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ofmap_size_i(ofmap_size_i),
    .ifmap_ch_i(ifmap_ch_i), .shift_i(shift_i), .relu_en_i(relu_en_i),
    .busy_o(busy_o), .done_o(done_o), .psum_i(psum_i), .pvalid_i(pvalid_i),
    .pready_o(pready_o), .conv_valid_o(conv_valid_o), .conv_ready_i(conv_ready_i),
    .conv_last_o(conv_last_o), .conv_result_o(conv_result_o), .addr_o(addr_o)
  );

  typedef struct { int res; int addr; int last; } exp_t;
  typedef struct { int ch; int sh; int rl; int p0; int p1; int p2; int exp; } vec_t;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   ps_q[N_COL][$];
  exp_t exp_q[N_COL][$];

  always @(negedge clk) if (done_o) done_cnt++;

  task automatic chk(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  // Reference requant with plain integer arithmetic (floor division by 2^sh).
  function automatic int ref_rq(input int acc, input int sh, input int rl);
    longint r, d, q;
    r = acc;
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
    d = longint'(1) << sh;
    if (r >= 0) q = r / d;
    else q = -((-r + d - 1) / d);
    if (rl != 0 && q < 0) q = 0;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  task automatic clear_model();
    for (int c = 0; c < N_COL; c++) begin
      ps_q[c].delete();
      exp_q[c].delete();
    end
  endtask

  task automatic fill_random(input int of, input int ch, input int sh, input int rl);
    exp_t e;
    int   s;
    clear_model();
    for (int c = 0; c < N_COL; c++) begin
      for (int i = 0; i < of * of * ch; i++) ps_q[c].push_back(int'($urandom_range(255)) - 128);
      for (int p = 0; p < of * of; p++) begin
        s = 0;
        for (int k = 0; k < ch; k++) s += ps_q[c][p * ch + k];
        e.res = ref_rq(s, sh, rl); e.addr = p; e.last = (p == of * of - 1) ? 1 : 0;
        exp_q[c].push_back(e);
      end
    end
  endtask

  // Starts a run, streams every lane's psums and checks every output handshake.
  // pv_pct < 0 selects a per-lane staggered valid rate; block0 holds lane 0 ready low.
  task automatic run_stream(input int of, input int ch, input int sh, input int rl,
                            input int pv_pct, input int rd_pct, input int block0);
    int   pi[N_COL];
    int   oi[N_COL];
    bit   hv[N_COL];
    int   hres[N_COL];
    int   had[N_COL];
    int   hls[N_COL];
    int   blk, done0, pv, res, ad, ls;
    bit   all_done, blocked0, vld, rdy;
    exp_t e;
    for (int c = 0; c < N_COL; c++) begin pi[c] = 0; oi[c] = 0; hv[c] = 0; end
    blk = 0; all_done = 0; done0 = done_cnt;
    ofmap_size_i = OF_W'(of); ifmap_ch_i = CH_W'(ch); shift_i = SH_W'(sh); relu_en_i = rl[0];
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    ofmap_size_i = OF_W'($urandom); ifmap_ch_i = CH_W'($urandom);
    shift_i = SH_W'($urandom); relu_en_i = 1'($urandom);
    chk("busy_after_start", busy_o, 1);
    for (int cyc = 0; cyc < 4000 && !all_done; cyc++) begin
      start_i = (cyc == 2);
      if (cyc == 2) begin
        ofmap_size_i = OF_W'(1 + $urandom_range(5)); ifmap_ch_i = CH_W'(1 + $urandom_range(7));
        shift_i = SH_W'($urandom_range(7)); relu_en_i = ~rl[0];
      end
      blocked0 = (blk < block0);
      for (int c = 0; c < N_COL; c++) begin
        pv = (pv_pct < 0) ? 10 + 5 * c : pv_pct;
        pvalid_i[c] = (pi[c] < ps_q[c].size()) && (int'($urandom_range(99)) < pv);
        psum_i[c*PSUM_W +: PSUM_W] = (pi[c] < ps_q[c].size()) ? PSUM_W'(ps_q[c][pi[c]]) : '0;
        conv_ready_i[c] = (int'($urandom_range(99)) < rd_pct);
      end
      if (blocked0) conv_ready_i[0] = 1'b0;
      #1;
      for (int c = 0; c < N_COL; c++) begin
        vld = conv_valid_o[c]; rdy = conv_ready_i[c];
        res = int'($signed(conv_result_o[c*OUT_W +: OUT_W]));
        ad  = int'(addr_o[c*ADDR_W +: ADDR_W]);
        ls  = int'(conv_last_o[c]);
        if (vld) begin
          if (hv[c]) begin
            chk($sformatf("hold_res[%0d]", c), res, hres[c]);
            chk($sformatf("hold_addr[%0d]", c), ad, had[c]);
            chk($sformatf("hold_last[%0d]", c), ls, hls[c]);
          end
          if (c == 0 && blocked0) blk++;
          if (rdy) begin
            chk($sformatf("out_count_ok[%0d]", c), (oi[c] < exp_q[c].size()) ? 1 : 0, 1);
            if (oi[c] < exp_q[c].size()) begin
              e = exp_q[c][oi[c]];
              chk($sformatf("res[%0d]", c), res, e.res);
              chk($sformatf("addr[%0d]", c), ad, e.addr);
              chk($sformatf("last[%0d]", c), ls, e.last);
            end
            oi[c]++; hv[c] = 0;
          end else begin
            hv[c] = 1; hres[c] = res; had[c] = ad; hls[c] = ls;
            chk($sformatf("pready_bp[%0d]", c), pready_o[c], 0);
          end
        end else begin
          hv[c] = 0;
        end
        if (pvalid_i[c] && pready_o[c]) pi[c]++;
      end
      all_done = 1;
      for (int c = 0; c < N_COL; c++)
        if (pi[c] < ps_q[c].size() || oi[c] < exp_q[c].size()) all_done = 0;
      @(negedge clk);
    end
    start_i = 1'b0; pvalid_i = '0; conv_ready_i = '1;
    chk("stream_complete", all_done, 1);
    for (int k = 0; k < 20 && busy_o; k++) @(negedge clk);
    chk("busy_end", busy_o, 0);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - done0, 1);
  endtask

  task automatic idle_outputs(input string name);
    chk({name, "_pready"}, pready_o, 0);
    chk({name, "_others"}, |{busy_o, done_o, conv_valid_o, conv_last_o, conv_result_o, addr_o}, 0);
  endtask

  vec_t vt[12];
  int   vp[3];
  int   d0;

  initial begin
    vt[0]  = '{3, 0, 0, 1, 2, 3, 6};
    vt[1]  = '{3, 0, 0, -4, -4, -4, -12};
    vt[2]  = '{3, 0, 0, 127, 127, 127, 127};
    vt[3]  = '{3, 0, 0, -128, -128, -128, -128};
    vt[4]  = '{3, 2, 0, 2, 2, 2, 2};
    vt[5]  = '{3, 2, 0, -2, -2, -2, -1};
    vt[6]  = '{3, 2, 1, -2, -2, -2, 0};
    vt[7]  = '{1, 0, 0, -7, 0, 0, -7};
    vt[8]  = '{2, 1, 0, 3, 2, 0, 3};
    vt[9]  = '{2, 1, 0, -3, -2, 0, -2};
    vt[10] = '{3, 4, 0, 127, 127, 127, 24};
    vt[11] = '{2, 0, 1, 100, 100, 0, 127};

    rst = 1'b1; start_i = 1'b0; ofmap_size_i = '0; ifmap_ch_i = '0; shift_i = '0;
    relu_en_i = 1'b0; psum_i = '0; pvalid_i = '0; conv_ready_i = '1;
    repeat (3) @(negedge clk);
    idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    idle_outputs("post_reset");

    // Single-pixel constant vectors on every lane.
    foreach (vt[i]) begin
      exp_t e;
      clear_model();
      vp[0] = vt[i].p0; vp[1] = vt[i].p1; vp[2] = vt[i].p2;
      for (int c = 0; c < N_COL; c++) begin
        for (int k = 0; k < vt[i].ch; k++) ps_q[c].push_back(vp[k]);
        e.res = vt[i].exp; e.addr = 0; e.last = 1;
        exp_q[c].push_back(e);
      end
      run_stream(1, vt[i].ch, vt[i].sh, vt[i].rl, 100, 100, 0);
    end

    // 2x2 ofmap, three channels: addr sequence, saturation and last flag.
    begin
      exp_t e;
      int seq[12] = '{1, 2, 3, -4, -4, -4, 127, 127, 127, -128, -128, -128};
      int er[4] = '{6, -12, 127, -128};
      clear_model();
      for (int c = 0; c < N_COL; c++) begin
        foreach (seq[k]) ps_q[c].push_back(seq[k]);
        for (int p = 0; p < 4; p++) begin
          e.res = er[p]; e.addr = p; e.last = (p == 3) ? 1 : 0;
          exp_q[c].push_back(e);
        end
      end
      run_stream(2, 3, 0, 0, 100, 100, 0);
    end

    // Starts with a zero channel count or zero ofmap size are ignored.
    d0 = done_cnt;
    ofmap_size_i = OF_W'(2); ifmap_ch_i = '0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("zero_ch_busy", busy_o, 0);
    ofmap_size_i = '0; ifmap_ch_i = CH_W'(3); start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("zero_of_busy", busy_o, 0);
    repeat (3) @(negedge clk);
    chk("zero_cfg_no_done", done_cnt - d0, 0);

    // Output backpressure with one channel per pixel.
    fill_random(3, 1, 0, 0);
    run_stream(3, 1, 0, 0, 100, 100, 5);

    // Staggered per-lane valid rates.
    fill_random(4, 3, 1, 0);
    run_stream(4, 3, 1, 0, -1, 70, 0);

    // Abort mid-accumulation, then a clean run.
    d0 = done_cnt;
    ofmap_size_i = OF_W'(2); ifmap_ch_i = CH_W'(4); shift_i = '0; relu_en_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < N_COL; c++) psum_i[c*PSUM_W +: PSUM_W] = PSUM_W'(50);
    pvalid_i = '1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    idle_outputs("mid_reset");
    @(negedge clk);
    pvalid_i = '0; rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_reset_no_done", done_cnt - d0, 0);
    fill_random(2, 4, 0, 0);
    run_stream(2, 4, 0, 0, 80, 80, 0);

    // Randomized configurations.
    for (int r = 0; r < 4; r++) begin
      int of, ch, sh, rl;
      of = 1 + $urandom_range(3); ch = 1 + $urandom_range(4);
      sh = $urandom_range(6); rl = $urandom_range(1);
      fill_random(of, ch, sh, rl);
      run_stream(of, ch, sh, rl, 60, 60, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
